// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encoding, FSM state
// encoding and the registered flag bundle.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_PASSA = 3'b000;
    localparam opcode_t OP_SUB   = 3'b001;
    localparam opcode_t OP_ADD   = 3'b010;
    localparam opcode_t OP_AND   = 3'b011;
    localparam opcode_t OP_XOR   = 3'b100;
    localparam opcode_t OP_PASSB = 3'b101;
    localparam opcode_t OP_MUL   = 3'b110;
    localparam opcode_t OP_OR    = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Flags travel with alu_out and always describe the same operation.
    typedef struct packed {
        logic a_is_zero;
        logic res_zero;
        logic carry;
    } alu_flags_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle of the multicycle ALU.
//   master: drives in_valid/opcode/in_a/in_b/out_ready, sees in_ready and results
//   slave : the ALU side of the same signals
interface alu_multicycle_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    opcode_t          opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             a_is_zero;
    logic             res_zero;
    logic             carry;

    modport master (
        output in_valid, opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, alu_out, a_is_zero, res_zero, carry
    );

    modport slave (
        input  in_valid, opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, alu_out, a_is_zero, res_zero, carry
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier.
//   start   : load operands; the first partial product is folded in on this edge
//   a, b    : operands, sampled only when start is high
//   done    : product holds the full result (high for one cycle)
//   product : 2*WIDTH-bit unsigned product
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [WIDTH-1:0] mplr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // cnt_q counts partial products already accumulated.
    assign done    = busy_q && (cnt_q == CNT_W'(WIDTH));
    assign product = acc_q;

    // Partial product i is added when multiplier bit i is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            acc_q   <= b[0] ? PW'(a) : '0;
            mcand_q <= PW'(a) << 1;
            mplr_q  <= b >> 1;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
        end else if (done) begin
            busy_q  <= 1'b0;
        end else if (busy_q) begin
            acc_q   <= acc_q + (mplr_q[0] ? mcand_q : '0);
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/add/sub ops, WIDTH-cycle multiply.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_multicycle_if.slave (request handshake, result handshake)
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_multicycle_if.slave   bus
);

    import alu_pkg::*;

    state_t           state;
    state_t           next_state;
    logic             in_ready_c;
    logic             accept_c;
    logic             mul_start_c;
    logic             mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;

    logic [WIDTH-1:0] alu_out_q;
    logic             out_valid_q;
    alu_flags_t       flags_q;
    logic             mul_a_zero_q;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_c),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (product)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake, next state and single-cycle result.
    always_comb begin
        next_state  = state;
        mul_start_c = 1'b0;
        res_c       = '0;
        carry_c     = 1'b0;
        sum_c       = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        in_ready_c  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
        accept_c    = bus.in_valid && in_ready_c;

        unique case (state)
            ST_IDLE: begin
                if (accept_c && (bus.opcode == OP_MUL)) begin
                    next_state  = ST_MUL;
                    mul_start_c = 1'b1;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    next_state = ST_IDLE;
                end
            end
        endcase

        unique case (bus.opcode)
            OP_PASSA: res_c = bus.in_a;
            OP_SUB: begin
                res_c   = bus.in_a - bus.in_b;
                carry_c = bus.in_a < bus.in_b;
            end
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
            end
            OP_AND:   res_c = bus.in_a & bus.in_b;
            OP_XOR:   res_c = bus.in_a ^ bus.in_b;
            OP_PASSB: res_c = bus.in_b;
            OP_MUL:   res_c = '0;
            OP_OR:    res_c = bus.in_a | bus.in_b;
        endcase
    end

    // Result registers: a finished multiply or a new single-cycle op loads,
    // otherwise a consumed result just drops out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q    <= '0;
            out_valid_q  <= 1'b0;
            flags_q      <= '0;
            mul_a_zero_q <= 1'b0;
        end else begin
            if ((state == ST_MUL) && mul_done) begin
                out_valid_q       <= 1'b1;
                alu_out_q         <= product[WIDTH-1:0];
                flags_q.carry     <= |product[2*WIDTH-1:WIDTH];
                flags_q.res_zero  <= (product[WIDTH-1:0] == '0);
                flags_q.a_is_zero <= mul_a_zero_q;
            end else if (accept_c && (bus.opcode != OP_MUL)) begin
                out_valid_q       <= 1'b1;
                alu_out_q         <= res_c;
                flags_q.carry     <= carry_c;
                flags_q.res_zero  <= (res_c == '0);
                flags_q.a_is_zero <= (bus.in_a == '0);
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // a_is_zero must describe the multiply's own operand.
            if (mul_start_c) begin
                mul_a_zero_q <= (bus.in_a == '0);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.a_is_zero = flags_q.a_is_zero;
    assign bus.res_zero  = flags_q.res_zero;
    assign bus.carry     = flags_q.carry;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL support any WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 opcode  input  3  operation select (REQ-012).
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 alu_out  output  WIDTH  result; a_is_zero  output  1  captured in_a == 0; res_zero  output  1  alu_out == 0; carry  output  1  carry/borrow/overflow flag.

Function
REQ-012 Opcodes SHALL be: 000 A; 001 A-B; 010 A+B; 011 A&B; 100 A^B; 101 B; 110 A*B (low WIDTH bits); 111 A|B.
REQ-013 Handshake: operation accepted on a rising edge where in_valid && in_ready; opcode/in_a/in_b SHALL be sampled only then.
REQ-014 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-015 FSM states IDLE, MUL; IDLE->MUL on accepting opcode 110; MUL->IDLE after WIDTH iteration cycles; all other accepts stay in IDLE.
REQ-016 Non-MUL ops: result, flags and out_valid=1 SHALL be registered on the accepting edge (latency 1 cycle).
REQ-017 MUL: shift-add over WIDTH cycles; out_valid SHALL rise on the WIDTH-th edge after the accepting edge; in_ready SHALL be 0 throughout MUL.
REQ-018 carry: ADD = bit WIDTH of the (WIDTH+1)-bit sum; SUB = 1 when A < B unsigned (borrow); MUL = 1 when upper WIDTH bits of the 2*WIDTH product are nonzero; all other ops = 0.
REQ-019 a_is_zero and res_zero SHALL be registered alongside alu_out and refer to the same operation.
REQ-020 All arithmetic unsigned, modulo 2^WIDTH on alu_out.
REQ-021 While out_valid && !out_ready, alu_out and flags SHALL remain stable and no new operation SHALL be accepted.
REQ-022 out_valid SHALL clear on an edge where out_valid && out_ready, unless a new non-MUL op is accepted on that same edge, in which case out_valid stays 1 with the new result (back-to-back throughput 1 op/cycle).
REQ-023 Out-of-range or unknown opcode values SHALL not occur (3-bit fully decoded); no default-to-A behaviour is required.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, out_valid=0, alu_out=0, a_is_zero=0, res_zero=0, carry=0, multiplier registers=0.
REQ-025 Reset asserted mid-MUL SHALL abort the multiply; no result SHALL be produced after release.
REQ-026 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Package alu_pkg SHALL hold opcode constants (OP_PASSA..OP_OR) and the FSM state encoding.
REQ-028 Iterative multiplier SHALL be sub-module alu_mul_iter (ports: clk, rst_n, start, a, b, done, product[2*WIDTH-1:0]); rest of the datapath in alu_multicycle.

Verification (WIDTH=8)
REQ-029 ADD A=0xF0 B=0x20, out_ready=1 -> 1 cycle later alu_out=0x10, carry=1, res_zero=0, a_is_zero=0.
REQ-030 SUB A=0x05 B=0x05 -> alu_out=0x00, res_zero=1, carry=0; SUB A=0x03 B=0x05 -> alu_out=0xFE, carry=1.
REQ-031 MUL A=0x10 B=0x11 -> in_ready=0 for 8 cycles, out_valid on 8th edge, alu_out=0x10, carry=1; MUL 0x0C*0x0A -> 0x78, carry=0.
REQ-032 Backpressure: XOR A=0xAA B=0xFF with out_ready=0 for 5 cycles -> alu_out=0x55 held, in_ready=0, new in_valid ignored until out_ready=1.
REQ-033 Back-to-back: AND, OR, PASSB on consecutive cycles, out_ready=1 -> three results on three consecutive cycles; PASSA A=0x00 -> a_is_zero=1.
REQ-034 rst_n pulsed low at MUL cycle 4 -> all outputs 0 immediately, state IDLE, no out_valid after release, next ADD completes normally.
